fft_agu_seq: RTL
================

Name: fft_agu_seq

Overview:
- Self-sequencing address generation unit for an in-place radix-2 DIT FFT of size N = 2**LOG2N.
- Owns the load, processing and unload counters, so the top level only supplies handshakes.
- Drives the two ping-pong sample RAM banks (dual-port, 1-cycle read latency) and the twiddle ROM.
- Generalises the fixed 512-point combinational AGU: any LOG2N, a butterfly pipeline delay on write addresses, and in/out handshakes.

Parameters:
- LOG2N, 9, log2 of FFT size; legal range 3..12.
- BFLY_LAT, 3, cycles from rd_addr issue to the matching butterfly result write; legal range 1..8.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a frame; sampled only in IDLE.
- in_valid  input  1  input sample present this cycle (LOAD).
- out_ready  input  1  consumer accepts a result read this cycle (UNLOAD).
- rd_addr_a, rd_addr_b  output  LOG2N  read addresses for the bank selected by rd_bank.
- rd_en  output  1  read strobe.
- rd_bank  output  1  bank to read.
- wr_addr_a, wr_addr_b  output  LOG2N  write addresses; wr_addr_b is meaningful only in PROC/DRAIN.
- wr_en  output  1  write strobe.
- wr_b_en  output  1  port-b write strobe; asserted only for butterfly writes.
- wr_bank  output  1  bank to write.
- twiddle_addr  output  LOG2N-1  twiddle ROM address, aligned with rd_addr.
- level  output  LOG2N bits wide, clog2 range  current FFT level.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last unload read.

Behaviour:
- Reset (asynchronous, reset low): state = IDLE; all counters = 0; every output = 0.
- IDLE:
  - start=1 -> LOAD; count cleared.
- LOAD:
  - Each in_valid cycle: wr_en=1, wr_bank=0, wr_addr_a = bitreverse(count) over LOG2N bits, count++.
  - in_valid=0: all strobes 0, count holds.
  - After write N-1 -> PROC, level=0, j=0.
- PROC, one butterfly issue per cycle, j = 0..N/2-1:
  - rd_en=1, rd_bank = level[0].
  - rd_addr_a = rotl_LOG2N(2j, level).
  - rd_addr_b = rotl_LOG2N(2j+1, level).
  - twiddle_addr = j & msk, where msk = low LOG2N-1 bits of (1<<(LOG2N-1)) arithmetically shifted right by level, i.e. the top `level` bits of j are kept.
  - rd_addr_a/b and rd_bank are delayed exactly BFLY_LAT cycles to produce wr_addr_a/b, wr_en, wr_b_en, with wr_bank = ~rd_bank of that issue.
  - After j = N/2-1 -> DRAIN.
- DRAIN:
  - No reads; the delayed writes keep flowing.
  - Lasts BFLY_LAT cycles, which guarantees no read-after-write hazard.
  - Then: level++, j=0 -> PROC; if the level just finished was LOG2N-1 -> UNLOAD.
- UNLOAD:
  - Result bank = LOG2N[0].
  - Each out_ready cycle: rd_en=1, rd_bank = result bank, rd_addr_a = count, count++.
  - out_ready=0: rd_en=0.
  - Read data is valid one cycle after rd_en (RAM latency; consumer tracks this).
  - After read N-1 -> IDLE, with done=1 on the following cycle.
- start is ignored while busy. in_valid is ignored outside LOAD; out_ready is ignored outside UNLOAD.
- Reset mid-frame: immediate return to IDLE; the delay pipeline is cleared, so no stale write strobes.
- Frame length with continuous handshakes: N + LOG2N*(N/2+BFLY_LAT) + N cycles.

Optional Feature:
- Macro: FFT_AGU_REGOUT_EN.
- Defined: every address, strobe, bank and twiddle output gets one extra output register stage. rd_* and twiddle_addr lag by 1 cycle; the write delay pipeline becomes BFLY_LAT+1 from internal issue, so relative read-to-write alignment is still BFLY_LAT. DRAIN length becomes BFLY_LAT+1, and done is delayed 1 cycle.
- Undefined: outputs are driven directly from state/counter logic, as described above.

Test Plan:
- LOG2N=3, BFLY_LAT=1, start then 8 consecutive in_valid:
  - wr_addr_a sequence = 0,4,2,6,1,5,3,7.
  - wr_bank=0 throughout; PROC entered on the next cycle.
- LOG2N=3 PROC level 0:
  - j=0..3 -> rd pairs (0,1),(2,3),(4,5),(6,7), twiddle_addr all 0, rd_bank=0.
  - Matching writes 1 cycle later on bank 1.
- LOG2N=3 level 1, j=1 -> rd (4,6), twiddle 0; j=3 -> rd (5,7), twiddle 2.
- LOG2N=3 level 2, j=3 -> rd (3,7), twiddle 3.
- LOG2N=3 UNLOAD: rd_bank=1 (LOG2N odd).
  - out_ready toggled 1,0,1,… -> rd_addr_a steps 0..7 only on ready cycles.
  - done pulses once; busy falls in the same cycle.
- Reset asserted mid-PROC level 1 -> all outputs 0 asynchronously; no wr_en for the following BFLY_LAT cycles; a new start runs a clean frame.

Source files
------------

// File: rtl/fft_agu_seq.sv
// -----------------------------------------------------------------------------
// fft_agu_seq
//   Self-sequencing address generation unit for an in-place radix-2 DIT FFT of
//   size N = 2**LOG2N. It owns the load, butterfly and unload counters and
//   drives two ping-pong sample RAM banks (dual-port, 1-cycle read latency)
//   plus the twiddle ROM. The top level only supplies handshakes.
//
//   Frame: IDLE -> LOAD (N bit-reversed writes to bank 0)
//               -> { PROC (N/2 butterfly issues) -> DRAIN } x LOG2N levels
//               -> UNLOAD (N natural-order reads from bank LOG2N[0]) -> IDLE.
//
// Parameters
//   LOG2N     log2 of FFT size (3..12)
//   BFLY_LAT  cycles from read issue to the matching butterfly write (1..8)
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start          begin a frame (sampled only in IDLE)
//   in_valid       input sample present (LOAD only)
//   out_ready      consumer takes a result read (UNLOAD only)
//   rd_addr_a/b    read addresses, rd_en read strobe, rd_bank bank to read
//   wr_addr_a/b    write addresses, wr_en write strobe, wr_b_en port-b strobe
//                  (butterfly writes only), wr_bank bank to write
//   twiddle_addr   twiddle ROM address, aligned with the read addresses
//   level          current FFT level
//   busy           high in any state other than IDLE
//   done           one-cycle pulse after the last unload read
//
// Optional build macro
//   FFT_AGU_REGOUT_EN  adds one register stage on every address, strobe, bank
//                      and twiddle output; DRAIN grows to BFLY_LAT+1 cycles and
//                      done is delayed by one cycle. Read-to-write alignment at
//                      the outputs stays BFLY_LAT.
// -----------------------------------------------------------------------------
module fft_agu_seq #(
  parameter int LOG2N    = 9,
  parameter int BFLY_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic             rd_en,
  output logic             rd_bank,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic             wr_en,
  output logic             wr_b_en,
  output logic             wr_bank,
  output logic [LOG2N-2:0] twiddle_addr,
  output logic [LOG2N-1:0] level,
  output logic             busy,
  output logic             done
);

  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;
`ifdef FFT_AGU_REGOUT_EN
  localparam int DRAIN_LEN = BFLY_LAT + 1;
`else
  localparam int DRAIN_LEN = BFLY_LAT;
`endif
  localparam int DCW = $clog2(DRAIN_LEN + 1);

  localparam logic [LOG2N-1:0] CNT_ZERO   = {LOG2N{1'b0}};
  localparam logic [LOG2N-1:0] CNT_ONE    = LOG2N'(1);
  localparam logic [LOG2N-1:0] CNT_LAST   = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] J_LAST     = LOG2N'(HALF - 1);
  localparam logic [LOG2N-1:0] LVL_LAST   = LOG2N'(LOG2N - 1);
  localparam logic [DCW-1:0]   DRAIN_ZERO = {DCW{1'b0}};
  localparam logic [DCW-1:0]   DRAIN_ONE  = DCW'(1);
  localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(DRAIN_LEN - 1);
  // An even number of ping-pong passes leaves the result in bank 0.
  localparam logic             RES_BANK   = 1'(LOG2N % 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PROC   = 3'd2,
    S_DRAIN  = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Address helpers
  // ---------------------------------------------------------------------------
  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = x[LOG2N-1-i];
    end
    return r;
  endfunction

  // Rotate left over LOG2N bits; sh is always below LOG2N.
  function automatic logic [LOG2N-1:0] rotl(input logic [LOG2N-1:0] x,
                                            input logic [LOG2N-1:0] sh);
    return (x << sh) | (x >> (LOG2N - int'(sh)));
  endfunction

  // Keeps the top `lvl` bits of j. Equivalent to sign-extending shift of
  // the MSB-only word right by lvl and dropping its top bit.
  function automatic logic [LOG2N-2:0] tw_mask(input logic [LOG2N-1:0] lvl);
    return ~({(LOG2N-1){1'b1}} >> lvl);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [LOG2N-1:0] level_q, level_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic             done_q, done_d;

  // Write delay line carrying each butterfly issue forward BFLY_LAT cycles.
  logic [BFLY_LAT-1:0]            pipe_vld_q, pipe_vld_d;
  logic [BFLY_LAT-1:0]            pipe_bank_q, pipe_bank_d;
  logic [BFLY_LAT-1:0][LOG2N-1:0] pipe_a_q, pipe_a_d;
  logic [BFLY_LAT-1:0][LOG2N-1:0] pipe_b_q, pipe_b_d;

  // Un-staged output values.
  logic             issue_s;
  logic             ld_wr_s;
  logic [LOG2N-1:0] ld_addr_s;
  logic             rd_en_d, rd_bank_d;
  logic [LOG2N-1:0] rd_addr_a_d, rd_addr_b_d;
  logic [LOG2N-2:0] twiddle_addr_d;
  logic             wr_en_d, wr_b_en_d, wr_bank_d;
  logic [LOG2N-1:0] wr_addr_a_d, wr_addr_b_d;

  // Next-state, counter updates, read-side outputs and load writes.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    level_d        = level_q;
    drain_d        = drain_q;
    done_d         = 1'b0;
    issue_s        = 1'b0;
    ld_wr_s        = 1'b0;
    ld_addr_s      = CNT_ZERO;
    rd_en_d        = 1'b0;
    rd_bank_d      = 1'b0;
    rd_addr_a_d    = CNT_ZERO;
    rd_addr_b_d    = CNT_ZERO;
    twiddle_addr_d = {(LOG2N-1){1'b0}};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          ld_wr_s   = 1'b1;
          ld_addr_s = bit_rev(cnt_q);
          if (cnt_q == CNT_LAST) begin
            state_d = S_PROC;
            cnt_d   = CNT_ZERO;
            level_d = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      S_PROC: begin
        issue_s        = 1'b1;
        rd_en_d        = 1'b1;
        rd_bank_d      = level_q[0];
        rd_addr_a_d    = rotl({cnt_q[LOG2N-2:0], 1'b0}, level_q);
        rd_addr_b_d    = rotl({cnt_q[LOG2N-2:0], 1'b1}, level_q);
        twiddle_addr_d = cnt_q[LOG2N-2:0] & tw_mask(level_q);
        if (cnt_q == J_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_ZERO;
          drain_d = DRAIN_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Lets the in-flight writes land before the next level reads them.
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = DRAIN_ZERO;
          if (level_q == LVL_LAST) begin
            state_d = S_UNLOAD;
            level_d = CNT_ZERO;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = S_PROC;
            level_d = level_q + CNT_ONE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          drain_d = drain_q + DRAIN_ONE;
        end
      end

      S_UNLOAD: begin
        if (out_ready) begin
          rd_en_d     = 1'b1;
          rd_bank_d   = RES_BANK;
          rd_addr_a_d = cnt_q;
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
        level_d = CNT_ZERO;
        drain_d = DRAIN_ZERO;
      end
    endcase
  end

  // Write delay line: stage 0 captures the current issue, the rest shift.
  always_comb begin
    pipe_vld_d     = pipe_vld_q;
    pipe_bank_d    = pipe_bank_q;
    pipe_a_d       = pipe_a_q;
    pipe_b_d       = pipe_b_q;
    pipe_vld_d[0]  = issue_s;
    pipe_bank_d[0] = issue_s & ~rd_bank_d;
    pipe_a_d[0]    = issue_s ? rd_addr_a_d : CNT_ZERO;
    pipe_b_d[0]    = issue_s ? rd_addr_b_d : CNT_ZERO;
    for (int k = 1; k < BFLY_LAT; k++) begin
      pipe_vld_d[k]  = pipe_vld_q[k-1];
      pipe_bank_d[k] = pipe_bank_q[k-1];
      pipe_a_d[k]    = pipe_a_q[k-1];
      pipe_b_d[k]    = pipe_b_q[k-1];
    end
  end

  // Write port mux: load writes and butterfly writes never overlap in time.
  always_comb begin
    wr_en_d     = ld_wr_s | pipe_vld_q[BFLY_LAT-1];
    wr_b_en_d   = pipe_vld_q[BFLY_LAT-1];
    wr_bank_d   = pipe_bank_q[BFLY_LAT-1];
    wr_addr_b_d = pipe_b_q[BFLY_LAT-1];
    if (ld_wr_s) begin
      wr_addr_a_d = ld_addr_s;
    end else begin
      wr_addr_a_d = pipe_a_q[BFLY_LAT-1];
    end
  end

  // State, counters and delay line registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= CNT_ZERO;
      level_q     <= CNT_ZERO;
      drain_q     <= DRAIN_ZERO;
      done_q      <= 1'b0;
      pipe_vld_q  <= {BFLY_LAT{1'b0}};
      pipe_bank_q <= {BFLY_LAT{1'b0}};
      pipe_a_q    <= {(BFLY_LAT*LOG2N){1'b0}};
      pipe_b_q    <= {(BFLY_LAT*LOG2N){1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      drain_q     <= drain_d;
      done_q      <= done_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_bank_q <= pipe_bank_d;
      pipe_a_q    <= pipe_a_d;
      pipe_b_q    <= pipe_b_d;
    end
  end

`ifdef FFT_AGU_REGOUT_EN
  logic             rd_en_q, rd_bank_q;
  logic [LOG2N-1:0] rd_addr_a_q, rd_addr_b_q;
  logic [LOG2N-2:0] twiddle_addr_q;
  logic             wr_en_q, wr_b_en_q, wr_bank_q;
  logic [LOG2N-1:0] wr_addr_a_q, wr_addr_b_q;
  logic             done_dly_q;

  // Output register stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en_q        <= 1'b0;
      rd_bank_q      <= 1'b0;
      rd_addr_a_q    <= CNT_ZERO;
      rd_addr_b_q    <= CNT_ZERO;
      twiddle_addr_q <= {(LOG2N-1){1'b0}};
      wr_en_q        <= 1'b0;
      wr_b_en_q      <= 1'b0;
      wr_bank_q      <= 1'b0;
      wr_addr_a_q    <= CNT_ZERO;
      wr_addr_b_q    <= CNT_ZERO;
      done_dly_q     <= 1'b0;
    end else begin
      rd_en_q        <= rd_en_d;
      rd_bank_q      <= rd_bank_d;
      rd_addr_a_q    <= rd_addr_a_d;
      rd_addr_b_q    <= rd_addr_b_d;
      twiddle_addr_q <= twiddle_addr_d;
      wr_en_q        <= wr_en_d;
      wr_b_en_q      <= wr_b_en_d;
      wr_bank_q      <= wr_bank_d;
      wr_addr_a_q    <= wr_addr_a_d;
      wr_addr_b_q    <= wr_addr_b_d;
      done_dly_q     <= done_q;
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_bank      = rd_bank_q;
  assign rd_addr_a    = rd_addr_a_q;
  assign rd_addr_b    = rd_addr_b_q;
  assign twiddle_addr = twiddle_addr_q;
  assign wr_en        = wr_en_q;
  assign wr_b_en      = wr_b_en_q;
  assign wr_bank      = wr_bank_q;
  assign wr_addr_a    = wr_addr_a_q;
  assign wr_addr_b    = wr_addr_b_q;
  assign done         = done_dly_q;
`else
  assign rd_en        = rd_en_d;
  assign rd_bank      = rd_bank_d;
  assign rd_addr_a    = rd_addr_a_d;
  assign rd_addr_b    = rd_addr_b_d;
  assign twiddle_addr = twiddle_addr_d;
  assign wr_en        = wr_en_d;
  assign wr_b_en      = wr_b_en_d;
  assign wr_bank      = wr_bank_d;
  assign wr_addr_a    = wr_addr_a_d;
  assign wr_addr_b    = wr_addr_b_d;
  assign done         = done_q;
`endif

  assign busy  = (state_q != S_IDLE);
  assign level = level_q;

endmodule
